// File: rtl/bsg_counter_set_down_en.sv
// bsg_counter_set_down_en: loadable down-counter with zero flag, expire pulse and optional auto-reload
module bsg_counter_set_down_en #(
  parameter int max_val_p = 1000,
  localparam int w = $clog2(max_val_p + 1)
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         set_i,
  input  logic [w-1:0] val_i,
  input  logic         reload_i,
  input  logic         en_i,
  output logic [w-1:0] count_o,
  output logic         zero_o,
  output logic         expire_o,
  output logic         busy_o
);
  typedef enum logic {IDLE, RUN} state_e;
  state_e state_r;
  logic [w-1:0] count_r, reload_val_r, ld;
  logic auto_r, expire_r;
  always_comb ld = (val_i > w'(max_val_p)) ? w'(max_val_p) : val_i;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_r      <= IDLE;
      count_r      <= '0;
      reload_val_r <= '0;
      auto_r       <= 1'b0;
      expire_r     <= 1'b0;
    end else if (set_i) begin
      count_r      <= ld;
      reload_val_r <= ld;
      auto_r       <= reload_i;
      expire_r     <= 1'b0;
      state_r      <= (ld != '0) ? RUN : IDLE;
    end else if (en_i && state_r == RUN && count_r != w'(1)) begin
      count_r  <= count_r - w'(1);
      expire_r <= 1'b0;
    end else if (en_i && state_r == RUN) begin
      expire_r <= 1'b1;
      count_r  <= auto_r ? reload_val_r : '0;
      state_r  <= auto_r ? RUN : IDLE;
    end else
      expire_r <= 1'b0;
  assign count_o  = count_r;
  assign zero_o   = (count_r == '0);
  assign expire_o = expire_r;
  assign busy_o   = (state_r == RUN);
endmodule

// File: tb/tb_bsg_counter_set_down_en.sv
// tb_bsg_counter_set_down_en: scoreboard bench for the loadable down-counter
module tb_bsg_counter_set_down_en;
  localparam int w = 10;
  logic clk_i = 1'b0, reset_n_i = 1'b0, set_i = 1'b0, reload_i = 1'b0, en_i = 1'b0;
  logic [w-1:0] val_i = '0, count_o;
  logic zero_o, expire_o, busy_o;
  int checks = 0, errors = 0;
  int m_cnt = 0, m_rel = 0;
  bit m_auto = 0, m_exp = 0, m_run = 0;
  logic [w+2:0] sb[$];
  bsg_counter_set_down_en dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .set_i(set_i), .val_i(val_i), .reload_i(reload_i),
    .en_i(en_i), .count_o(count_o), .zero_o(zero_o), .expire_o(expire_o), .busy_o(busy_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input bit s, input int v, input bit r, input bit e);
    logic [w+2:0] x;
    int ld;
    @(negedge clk_i);
    set_i = s; val_i = w'(v); reload_i = r; en_i = e;
    if (s) begin
      ld = (v > 1000) ? 1000 : v;
      m_cnt = ld; m_rel = ld; m_auto = r; m_exp = 0; m_run = (ld != 0);
    end else if (e && m_run && m_cnt == 1) begin
      m_exp = 1;
      if (m_auto) m_cnt = m_rel;
      else begin m_cnt = 0; m_run = 0; end
    end else if (e && m_run) begin
      m_cnt = m_cnt - 1; m_exp = 0;
    end else m_exp = 0;
    sb.push_back({w'(m_cnt), m_cnt == 0, m_exp, m_run});
    @(posedge clk_i);
    #1;
    x = sb.pop_front();
    check("count", int'(count_o), int'(x[w+2:3]));
    check("zero", int'(zero_o), int'(x[2]));
    check("expire", int'(expire_o), int'(x[1]));
    check("busy", int'(busy_o), int'(x[0]));
  endtask
  initial begin
    int seq[6] = '{1, 2, 1, 2, 1, 2};
    #2;
    check("rst_count", int'(count_o), 0);
    check("rst_zero", int'(zero_o), 1);
    check("rst_expire", int'(expire_o), 0);
    check("rst_busy", int'(busy_o), 0);
    @(negedge clk_i) reset_n_i = 1'b1;
    step(1, 5, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("mid_count_before_rst", int'(count_o), 3);
    #2 reset_n_i = 1'b0;
    #1;
    check("mid_rst_count", int'(count_o), 0);
    check("mid_rst_zero", int'(zero_o), 1);
    check("mid_rst_busy", int'(busy_o), 0);
    check("mid_rst_expire", int'(expire_o), 0);
    m_cnt = 0; m_rel = 0; m_auto = 0; m_exp = 0; m_run = 0;
    @(negedge clk_i) reset_n_i = 1'b1;
    step(1, 3, 0, 0);
    check("oneshot_load", int'(count_o), 3);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    step(1, 1023, 0, 0);
    check("clamp", int'(count_o), 1000);
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
    check("saturate", int'(count_o), 0);
    step(1, 2, 1, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 1);
      check("auto_seq", int'(count_o), seq[i]);
    end
    step(1, 1, 0, 0);
    step(1, 7, 0, 1);
    check("collide_count", int'(count_o), 7);
    check("collide_expire", int'(expire_o), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 1);
    step(1, 4, 0, 1);
    step(0, 0, 0, 1);
    step(1, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    step(1, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 40; i++) step($urandom_range(0, 5) == 0, $urandom_range(0, 6), $urandom_range(0, 1), $urandom_range(0, 3) != 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bsg_counter_set_down_en.md
# bsg_counter_set_down_en

Loadable down-counter / interval timer with enable, the consuming counterpart of the up-counting `bsg_counter_set_en` family. `set_i` loads a start value; `en_i` decrements it toward zero. The block flags zero, pulses `expire_o` on the 1→0 step and can optionally reload automatically. It sits in timeout, credit-drain and periodic-tick paths wherever a loaded value must be consumed one step at a time.

## Interface
- `max_val_p`, default 1000: largest loadable count. Width `w = $clog2(max_val_p+1)`, which is 10 at the default.
- `clk_i`, input, 1: single clock; all state updates on its rising edge.
- `reset_n_i`, input, 1: asynchronous, active-low reset.
- `set_i`, input, 1: load `val_i` (clamped) into the count and capture the reload mode.
- `val_i`, input, w: start value, also stored as the reload value.
- `reload_i`, input, 1: sampled only when `set_i`=1. A value of 1 selects auto-reload mode.
- `en_i`, input, 1: decrement request.
- `count_o`, output, w: current count (registered).
- `zero_o`, output, 1: `count_o == 0` (combinational decode of the register).
- `expire_o`, output, 1: one-cycle registered pulse when the count is consumed from 1.
- `busy_o`, output, 1: 1 while in the RUN state.

## Operation
- Internal registers:
  - `count_r` (w bits)
  - `reload_val_r` (w bits)
  - `auto_r` (1 bit)
  - `expire_r` (1 bit)
  - state ∈ {IDLE, RUN}
- Clamp: `ld = (val_i > max_val_p) ? max_val_p : val_i`.
- Priority each cycle is set > en > hold.
- `set_i`=1, whatever the value of `en_i`:
  - `count_r` ← `ld`, `reload_val_r` ← `ld`, `auto_r` ← `reload_i`, `expire_r` ← 0.
  - state ← RUN if `ld` ≠ 0, else IDLE.
- `set_i`=0, `en_i`=1, state RUN, `count_r` > 1:
  - `count_r` ← `count_r` − 1; `expire_r` ← 0.
- `set_i`=0, `en_i`=1, state RUN, `count_r` == 1:
  - `expire_r` ← 1.
  - If `auto_r`=1: `count_r` ← `reload_val_r` and state stays RUN.
  - If `auto_r`=0: `count_r` ← 0 and state ← IDLE.
- `set_i`=0, `en_i`=1, state IDLE:
  - No change; the count saturates at 0 and never underflows.
  - `expire_r` ← 0.
- `set_i`=0, `en_i`=0: count and state hold; `expire_r` ← 0.
- Reload value of 1 with `auto_r`=1 produces an `expire_o` pulse on every enabled cycle while `count_o` stays at 1.
- Outputs: `busy_o` = (state == RUN); `expire_o` = `expire_r`; `count_o` = `count_r`.
- All arithmetic is unsigned, w bits; a decrement is only applied when `count_r` ≥ 1.

## Timing
- Reset (asynchronous, while `reset_n_i`=0):
  - `count_o`=0, `zero_o`=1, `expire_o`=0, `busy_o`=0.
  - state IDLE, `auto_r`=0, `reload_val_r`=0.
- Reset may assert mid-count: state is cleared immediately, with no expire pulse.
- Deassertion is taken synchronously by the integrator. The first edge with `reset_n_i`=1 may carry a `set_i`.
- Load latency: `set_i` at edge k makes `count_o`=`ld` visible after edge k; `busy_o` and `zero_o` update at the same time.
- Decrement latency: one cycle per enabled edge. There are no internal bubbles, so `en_i` may be held high continuously.
- Expire timing: for edge k with `count_r`=1 and `en_i`=1, `expire_o` is 1 for exactly the cycle after edge k.
  - In that cycle `count_o` shows 0, or the reload value when `auto_r`=1.
- Simultaneous events:
  - `set_i` and `en_i` at `count_r`=1: load wins and no expire pulse is generated.
  - `set_i` in the cycle `expire_o`=1: the pulse still completes its single cycle, and the load takes effect normally.
- Loading 0 (or `val_i`=0): goes to IDLE immediately with no expire pulse, even if `reload_i`=1.

## Test plan
- **Reset mid-run.**
  - Stimulus: load 5, apply 2 enables, then pulse `reset_n_i` low asynchronously between clock edges.
  - Required: `count_o`=0, `zero_o`=1 and `busy_o`=0 immediately; `expire_o` never asserts.
- **One-shot countdown.**
  - Stimulus: `set_i` with `val_i`=3 and `reload_i`=0, then `en_i` held high for 5 cycles.
  - Required: `count_o` sequence 3,2,1,0,0,0; `expire_o`=1 only in the cycle `count_o` first reads 0; `busy_o` falls in that same cycle.
- **Clamp and saturation.**
  - Stimulus: `val_i`=1023 at the default `max_val_p`=1000.
  - Required: `count_o`=1000 after load. Separately, with the count at 0, 10 enables leave `count_o` at 0 and never wrap to 1023.
- **Auto-reload.**
  - Stimulus: `set_i` with `val_i`=2 and `reload_i`=1, then `en_i` held high for 6 cycles.
  - Required: `count_o` sequence 2,1,2,1,2,1,2; `expire_o` pulses on each 1→2 step; `busy_o` stays 1 and `zero_o` stays 0 throughout.
- **Set/enable collision.**
  - Stimulus: with count 1, assert `set_i` (`val_i`=7) and `en_i` in the same cycle.
  - Required: `count_o`=7 on the next cycle with no `expire_o` pulse. A gap in `en_i` (low for 3 cycles) holds 7.
- **Zero load.**
  - Stimulus: `set_i` with `val_i`=0 and `reload_i`=1, then `en_i` high.
  - Required: `count_o`=0, `busy_o`=0, `zero_o`=1, `expire_o`=0 on every cycle.
